// File: rtl/median_sorted_window_if.sv
// Sample/median bundle between the delay-line FIFO side and the running-median core.
// The master drives the new and outgoing samples; the slave returns median and status.
interface median_sorted_window_if #(
    parameter int unsigned DATA_LENGTH = 16
);
    logic [DATA_LENGTH-1:0] in_new;
    logic [DATA_LENGTH-1:0] in_old;
    logic [DATA_LENGTH-1:0] med_out;
    logic                   med_valid;
    logic                   err;

    modport master (
        output in_new,
        output in_old,
        input  med_out,
        input  med_valid,
        input  err
    );

    modport slave (
        input  in_new,
        input  in_old,
        output med_out,
        output med_valid,
        output err
    );
endinterface

// File: rtl/median_sorted_window.sv
// Running-median core: keeps the last W samples sorted, deleting the outgoing sample and
// inserting the new one each clock, and presents the middle element from a register.
module median_sorted_window #(
    parameter int unsigned DATA_LENGTH = 16,
    parameter int unsigned W           = 101,
    parameter bit          SIGNED      = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    median_sorted_window_if.slave  win
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam int unsigned Mid  = (W - 1) / 2;
    localparam logic [CntW-1:0] CntFull = CntW'(W);

    typedef logic [DATA_LENGTH-1:0] sample_t;

    sample_t         s_q [W];
    sample_t         s_d [W];
    sample_t         t   [W-1];
    logic [W-2:0]    gone;
    logic [W-2:0]    le;
    logic            found;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    function automatic logic le_cmp(input sample_t a, input sample_t b);
        if (SIGNED) begin
            return $signed(a) <= $signed(b);
        end else begin
            return a <= b;
        end
    endfunction

    // gone[j] marks slots at or above the deleted entry; when in_old is absent nothing
    // below W-1 is marked, so the top (maximum) entry is the one dropped.
    always_comb begin
        found = 1'b0;
        for (int j = 0; j < int'(W) - 1; j++) begin
            found   = found | (s_q[j] == win.in_old);
            gone[j] = found;
        end
        found = found | (s_q[W-1] == win.in_old);

        for (int j = 0; j < int'(W) - 1; j++) begin
            t[j]  = gone[j] ? s_q[j+1] : s_q[j];
            le[j] = le_cmp(t[j], win.in_new);
        end

        // le is a prefix of ones over the sorted W-1 list; the new sample lands right
        // after the last entry <= it, so ties stack above equal values.
        s_d[0] = le[0] ? t[0] : win.in_new;
        for (int i = 1; i < int'(W) - 1; i++) begin
            if (le[i]) begin
                s_d[i] = t[i];
            end else if (le[i-1]) begin
                s_d[i] = win.in_new;
            end else begin
                s_d[i] = t[i-1];
            end
        end
        s_d[W-1] = le[W-2] ? win.in_new : t[W-2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(W); i++) begin
                s_q[i] <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(W); i++) begin
                s_q[i] <= s_d[i];
            end
            if (cnt_q != CntFull) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (!found) begin
                err_q <= 1'b1;
            end
        end
    end

    assign win.med_out   = s_q[Mid];
    assign win.med_valid = (cnt_q == CntFull);
    assign win.err       = err_q;

endmodule

// File: tb/tb_median_sorted_window.sv
// Directed bench for median_sorted_window: an unsigned and a signed instance share one
// stimulus stream fed through a delay-line model of the upstream FIFO.
module tb_median_sorted_window;

    localparam int unsigned DL = 16;
    localparam int unsigned WL = 101;

    logic          clk = 1'b0;
    logic          reset;
    logic [DL-1:0] in_new;
    logic [DL-1:0] in_old;

    logic [DL-1:0] hist [WL];
    int            ptr;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    median_sorted_window_if #(.DATA_LENGTH(DL)) bus_u ();
    median_sorted_window_if #(.DATA_LENGTH(DL)) bus_s ();

    assign bus_u.in_new = in_new;
    assign bus_u.in_old = in_old;
    assign bus_s.in_new = in_new;
    assign bus_s.in_old = in_old;

    median_sorted_window #(.DATA_LENGTH(DL), .W(WL), .SIGNED(1'b0)) u_dut_u (
        .clk   (clk),
        .reset (reset),
        .win   (bus_u)
    );

    median_sorted_window #(.DATA_LENGTH(DL), .W(WL), .SIGNED(1'b1)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .win   (bus_s)
    );

    task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_u(input string tag, input logic [DL-1:0] med, input logic vld,
                           input logic er);
        check({tag, "_u_med"}, bus_u.med_out, med);
        check({tag, "_u_valid"}, 16'(bus_u.med_valid), 16'(vld));
        check({tag, "_u_err"}, 16'(bus_u.err), 16'(er));
    endtask

    task automatic check_s(input string tag, input logic [DL-1:0] med, input logic vld,
                           input logic er);
        check({tag, "_s_med"}, bus_s.med_out, med);
        check({tag, "_s_valid"}, 16'(bus_s.med_valid), 16'(vld));
        check({tag, "_s_err"}, 16'(bus_s.err), 16'(er));
    endtask

    task automatic check_all(input string tag, input logic [DL-1:0] med, input logic vld,
                             input logic er);
        check_u(tag, med, vld, er);
        check_s(tag, med, vld, er);
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(WL); i++) begin
            hist[i] = '0;
        end
        ptr = 0;
    endtask

    task automatic step_raw(input logic [DL-1:0] nv, input logic [DL-1:0] ov);
        in_new = nv;
        in_old = ov;
        @(posedge clk);
        #1;
    endtask

    // Delay-line model: the sample leaving is the one written W steps ago.
    task automatic step(input logic [DL-1:0] nv);
        logic [DL-1:0] ov;
        ov        = hist[ptr];
        hist[ptr] = nv;
        ptr       = (ptr + 1) % int'(WL);
        step_raw(nv, ov);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        in_new = '0;
        in_old = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    initial begin
        reset  = 1'b1;
        in_new = '0;
        in_old = '0;
        clear_model();

        // Reset held three cycles with random inputs
        for (int c = 0; c < 3; c++) begin
            in_new = 16'($urandom);
            in_old = 16'($urandom);
            @(posedge clk);
            #1;
            check_all("reset", 16'd0, 1'b0, 1'b0);
        end

        // Ramp 1..101 then one more
        do_reset();
        for (int n = 1; n <= 102; n++) begin
            step(16'(n));
            if (n == 50)  check_all("ramp_e50", 16'd0, 1'b0, 1'b0);
            if (n == 51)  check_all("ramp_e51", 16'd1, 1'b0, 1'b0);
            if (n == 100) check_all("ramp_e100", 16'd50, 1'b0, 1'b0);
            if (n == 101) check_all("ramp_e101", 16'd51, 1'b1, 1'b0);
            if (n == 102) check_all("ramp_e102", 16'd52, 1'b1, 1'b0);
        end

        // Constant 7
        do_reset();
        for (int n = 1; n <= 101; n++) begin
            step(16'd7);
            if (n == 50)  check_all("const_e50", 16'd0, 1'b0, 1'b0);
            if (n == 51)  check_all("const_e51", 16'd7, 1'b0, 1'b0);
            if (n == 100) check_all("const_e100", 16'd7, 1'b0, 1'b0);
            if (n == 101) check_all("const_e101", 16'd7, 1'b1, 1'b0);
        end

        // Spike rejection; steady 10s also exercise in_new == in_old
        do_reset();
        repeat (101) step(16'd10);
        check_all("steady", 16'd10, 1'b1, 1'b0);
        step(16'd1000);
        check_all("spike", 16'd10, 1'b1, 1'b0);
        for (int k = 0; k < 102; k++) begin
            step(16'd10);
            check_all("post_spike", 16'd10, 1'b1, 1'b0);
        end

        // Two-valued window: 51 x -3, 50 x +2, then two more +2
        do_reset();
        repeat (51) step(16'hFFFD);
        repeat (50) step(16'd2);
        check_all("mix_fill", 16'hFFFD, 1'b1, 1'b0);
        step(16'd2);
        step(16'd2);
        check_all("mix_push", 16'd2, 1'b1, 1'b0);

        // Three-valued window separates signed from unsigned ordering
        do_reset();
        repeat (34) step(16'hFFFD);
        repeat (34) step(16'd1);
        repeat (33) step(16'd5);
        check_u("order", 16'd5, 1'b1, 1'b0);
        check_s("order", 16'd1, 1'b1, 1'b0);

        // Absent in_old: max dropped, err sticky, reset clears everything
        do_reset();
        for (int k = 1; k <= 101; k++) begin
            step(16'(2 * k));
        end
        check_all("even_fill", 16'd102, 1'b1, 1'b0);
        step_raw(16'd1, 16'd5);
        check_all("absent1", 16'd100, 1'b1, 1'b1);
        step_raw(16'd1, 16'd5);
        check_all("absent2", 16'd98, 1'b1, 1'b1);
        step_raw(16'd300, 16'd100);
        check_all("sticky", 16'd98, 1'b1, 1'b1);
        do_reset();
        check_all("post_reset", 16'd0, 1'b0, 1'b0);
        step_raw(16'd3, 16'd0);
        check_all("post_reset_step", 16'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
